// File: rtl/fix_buf_pkg.sv
// Shared types and defaults for the outbound FIX message buffer.
package fix_buf_pkg;

  localparam int unsigned DEPTH_DEF = 256;
  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned DW_DEF    = 8;

  // FIX field separator, used by the message generator
  localparam logic [7:0] FIX_SOH = 8'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/fix_buf_ram.sv
// Simple dual-port message RAM: one write port, one registered read port.
module fix_buf_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port; the array itself is never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read; output register clears on reset and holds when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fix_msg_buffer.sv
// Stores one outbound FIX message, computes its checksum and replays it to the slave.
module fix_msg_buffer
  import fix_buf_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  output logic          wr_ready,
  input  logic [7:0]    session_initiate,
  input  logic          read_request,
  output logic [DW-1:0] data_out_2,
  output logic [AW-1:0] final_index,
  output logic          fix_message_sent,
  output logic [7:0]    checksum,
  output logic          overflow
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] final_index_q;
  logic          sent_q;
  logic [7:0]    checksum_q;
  logic [7:0]    acc_q;
  logic          overflow_q;

  logic          abort_c;
  logic          accept_c;
  logic          at_end_c;
  logic          last_c;
  logic          rd_en_c;
  logic [7:0]    acc_d;

  // Handshake and derived strobes
  assign abort_c  = |session_initiate;
  assign wr_ready = ((state_q == IDLE) || (state_q == FILL)) && reset && !abort_c;
  assign accept_c = wr_valid && wr_ready;
  assign at_end_c = (wr_ptr_q == LAST_ADDR);
  assign last_c   = wr_last || at_end_c;
  assign acc_d    = acc_q + 8'(wr_data);
  assign rd_en_c  = reset && !abort_c && read_request &&
                    ((state_q == HOLD) || (state_q == DRAIN));

  // Control FSM, pointers, checksum and status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      final_index_q <= '0;
      sent_q        <= 1'b0;
      checksum_q    <= '0;
      acc_q         <= '0;
      overflow_q    <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      if (abort_c) begin
        state_q    <= IDLE;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        acc_q      <= '0;
        overflow_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, FILL: begin
            if (accept_c) begin
              wr_ptr_q <= wr_ptr_q + AW'(1);
              acc_q    <= acc_d;
              if (state_q == IDLE) begin
                overflow_q <= 1'b0;
              end
              if (last_c) begin
                // Full buffer without wr_last closes the message as truncated
                state_q       <= HOLD;
                final_index_q <= wr_ptr_q;
                checksum_q    <= acc_d;
                sent_q        <= 1'b1;
                if (at_end_c && !wr_last) begin
                  overflow_q <= 1'b1;
                end
              end else begin
                state_q <= FILL;
              end
            end
          end
          HOLD, DRAIN: begin
            if (read_request) begin
              state_q <= DRAIN;
              if (rd_ptr_q != final_index_q) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
              end
            end else if (state_q == DRAIN) begin
              state_q  <= IDLE;
              wr_ptr_q <= '0;
              rd_ptr_q <= '0;
              acc_q    <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  fix_buf_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (accept_c),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd_en_c),
    .raddr (rd_ptr_q),
    .rdata (data_out_2)
  );

  assign final_index      = final_index_q;
  assign fix_message_sent = sent_q;
  assign checksum         = checksum_q;
  assign overflow         = overflow_q;

endmodule

// File: doc/fix_msg_buffer.md
Name: fix_msg_buffer

Overview:
Message store that sits directly upstream of the Avalon-MM status/data slave. It accepts one outbound FIX message byte-by-byte from the message generator and stores it in an internal RAM. It computes the FIX checksum and publishes final_index and a fix_message_sent pulse to the slave. While the slave holds read_request high, it streams the stored bytes back on data_out_2, mirroring the slave's own index.

Parameters:
DEPTH, 256, message buffer capacity in bytes (power of two)
AW, 8, address width = log2(DEPTH); also width of final_index
DW, 8, byte width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk
wr_valid  input  1  generator presents a message byte
wr_data  input  DW  message byte
wr_last  input  1  marks the final byte of the message (qualified by wr_valid)
wr_ready  output  1  buffer can accept a byte this cycle
session_initiate  input  8  from slave; any nonzero value aborts and clears the buffer
read_request  input  1  from slave; high while the slave drains the message
data_out_2  output  DW  byte at the current read pointer, one cycle latency
final_index  output  AW  address of the last stored byte
fix_message_sent  output  1  single-cycle pulse: message complete and ready to read
checksum  output  8  sum of all stored bytes mod 256, valid once fix_message_sent has pulsed
overflow  output  1  sticky flag: message truncated at DEPTH bytes

Behaviour:
- Reset (reset==0) clears the following: state=IDLE, wr_ptr=0, rd_ptr=0, final_index=0, data_out_2=0, fix_message_sent=0, checksum=0, accumulator=0, overflow=0. wr_ready is 0 while reset is low.
- States:
  - IDLE: empty.
  - FILL: receiving bytes.
  - HOLD: message complete, waiting for the drain.
  - DRAIN: slave is reading.
- wr_ready is combinational: (state==IDLE or FILL) and reset==1 and session_initiate==0.
- Accept condition: wr_valid & wr_ready. On accept, mem[wr_ptr] <= wr_data, wr_ptr += 1, and accumulator += wr_data (8-bit wrap).
- IDLE->FILL on an accept with wr_last=0. On that same transition, overflow clears.
- IDLE/FILL->HOLD on an accept with wr_last=1. In that cycle, final_index <= wr_ptr and checksum <= accumulator+wr_data. fix_message_sent is high for exactly the next cycle. A one-byte message is legal and gives final_index=0.
- Overflow: an accept at wr_ptr==DEPTH-1 with wr_last=0 is treated as last. overflow <= 1 and final_index = DEPTH-1.
- HOLD->DRAIN when read_request==1.
- In DRAIN, each cycle that read_request==1:
  - data_out_2 <= mem[rd_ptr];
  - rd_ptr increments, saturating at final_index.
- DRAIN->IDLE on the first cycle with read_request==0. wr_ptr, rd_ptr and the accumulator clear to 0. data_out_2, final_index, checksum and overflow hold their values.
- read_request in IDLE/FILL is ignored: rd_ptr stays 0 and data_out_2 holds.
- Abort: session_initiate!=0 in any state forces IDLE and clears wr_ptr, rd_ptr, accumulator and overflow. It does not pulse fix_message_sent. It has priority over a simultaneous write, which is not accepted because wr_ready is 0.
- Reset has priority over everything. Reset mid-FILL or mid-DRAIN discards the message.
- The RAM is simple dual-port with a registered read. Writes and reads never overlap, because FILL and DRAIN are exclusive.

Decomposition:
- Package fix_buf_pkg holds:
  - the state enum {IDLE, FILL, HOLD, DRAIN};
  - DEPTH/AW/DW defaults;
  - the FIX SOH constant 8'h01, for use by the generator.
- One sub-module, fix_buf_ram: parameterised DEPTH x DW, 1 write port, 1 registered read port.
- FSM, pointers and checksum live in the top.

Test Plan:
1. Write 0x38,0x3D,0x46,0x49,0x58 with wr_last on the fifth byte -> final_index=4, checksum=0x5C, fix_message_sent high exactly 1 cycle, wr_ready=0 afterwards.
2. After test 1, hold read_request high for 6 cycles then drop it -> data_out_2 = 0x38,0x3D,0x46,0x49,0x58,0x58 (one cycle after each request cycle, saturating). On the drop -> IDLE, and wr_ready=1 next cycle.
3. Single byte 0x41 with wr_last -> HOLD directly, final_index=0, checksum=0x41, one fix_message_sent pulse.
4. 257 consecutive valid bytes with no wr_last -> 256 accepted, overflow=1, final_index=255, wr_ready=0 on the 257th. A new accept after a drain clears overflow.
5. Three bytes in FILL, then session_initiate=0x01 together with wr_valid -> byte not accepted, state IDLE, no pulse. A following 2-byte message gives final_index=1 and a checksum over only those 2 bytes.
6. Drive reset=0 for 2 cycles mid-DRAIN -> all outputs 0, wr_ready=0 while low. wr_ready=1 on the first cycle after reset returns high, and read_request is ignored until a new message completes.
